// File: rtl/mmu_sched.sv
// Host-side scheduler for a 2x2 weight-stationary matrix unit: loads weights and
// activations, sequences clear/skewed feed/drain, then streams the results back.
module mmu_sched #(
  parameter int MMU_LATENCY = 3,
  parameter int ACC_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          mmu_weights,
  output logic                 mmu_load_w,
  output logic                 mmu_clear,
  output logic [7:0]           mmu_row0,
  output logic [7:0]           mmu_row1,
  output logic                 mmu_feed_valid,
  input  logic [4*ACC_W-1:0]   mmu_c,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int BPE    = ACC_W / 8;
  localparam int NBYTES = 4 * BPE;
  localparam int OIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DRN_W  = (MMU_LATENCY > 1) ? $clog2(MMU_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t              r_state;
  logic [2:0]          r_in_idx;
  logic [23:0]         r_w_stage;
  logic [31:0]         r_weights;
  logic [7:0]          r_a [4];
  logic [1:0]          r_feed_cnt;
  logic [DRN_W-1:0]    r_drain_cnt;
  logic [4*ACC_W-1:0]  r_result;
  logic [OIDX_W-1:0]   r_out_idx;
  logic                r_load_w;
  logic                r_clear;
  logic                r_feed_valid;
  logic [7:0]          r_row0;
  logic [7:0]          r_row1;

  logic                w_in_fire;
  logic                w_out_fire;
  logic [7:0]          w_out_byte;

  assign w_in_fire  = in_valid && (r_state == S_LOAD);
  assign w_out_fire = out_ready && (r_state == S_OUT);

  // Handshake and strobe outputs are forced low combinationally while rst is high,
  // so nothing leaks out in the cycle reset is first seen.
  assign in_ready       = (r_state == S_LOAD) && !rst;
  assign busy           = (r_state != S_LOAD) && !rst;
  assign out_valid      = (r_state == S_OUT) && !rst;
  assign mmu_load_w     = r_load_w && !rst;
  assign mmu_clear      = r_clear && !rst;
  assign mmu_feed_valid = r_feed_valid && !rst;
  assign mmu_row0       = rst ? 8'd0 : r_row0;
  assign mmu_row1       = rst ? 8'd0 : r_row1;
  assign mmu_weights    = r_weights;
  assign out_data       = out_valid ? w_out_byte : 8'd0;

  // Byte k walks C00..C11, most-significant byte of each accumulator first.
  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves the output held (no latch).
    w_out_byte = 8'd0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_out_idx == OIDX_W'(k)) begin
        w_out_byte = r_result[(k / BPE) * ACC_W + (BPE - 1 - (k % BPE)) * 8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the small operand file is reset along with everything else so an aborted job leaves no residue.
      r_state      <= S_LOAD;
      r_in_idx     <= 3'd0;
      r_w_stage    <= 24'd0;
      r_weights    <= 32'd0;
      for (int i = 0; i < 4; i++) r_a[i] <= 8'd0;
      r_feed_cnt   <= 2'd0;
      r_drain_cnt  <= '0;
      r_result     <= '0;
      r_out_idx    <= '0;
      r_load_w     <= 1'b0;
      r_clear      <= 1'b0;
      r_feed_valid <= 1'b0;
      r_row0       <= 8'd0;
      r_row1       <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      r_load_w <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_in_idx <= r_in_idx + 3'd1;
            case (r_in_idx)
              3'd0: r_w_stage[7:0]   <= in_data;
              3'd1: r_w_stage[15:8]  <= in_data;
              3'd2: r_w_stage[23:16] <= in_data;
              3'd3: begin
                // The whole weight word swaps at W11 so the array never sees a mixed set.
                r_weights <= {in_data, r_w_stage};
                r_load_w  <= 1'b1;
              end
              default: r_a[r_in_idx[1:0]] <= in_data;
            endcase
            if (r_in_idx == 3'd7) begin
              r_state <= S_CLEAR;
              r_clear <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          r_clear      <= 1'b0;
          r_state      <= S_FEED;
          r_feed_cnt   <= 2'd0;
          r_feed_valid <= 1'b1;
          r_row0       <= r_a[0];
          r_row1       <= 8'd0;
        end

        S_FEED: begin
          // Row 1 lags row 0 by one beat to match the systolic skew.
          case (r_feed_cnt)
            2'd0: begin
              r_row0     <= r_a[2];
              r_row1     <= r_a[1];
              r_feed_cnt <= 2'd1;
            end
            2'd1: begin
              r_row0     <= 8'd0;
              r_row1     <= r_a[3];
              r_feed_cnt <= 2'd2;
            end
            default: begin
              r_row0       <= 8'd0;
              r_row1       <= 8'd0;
              r_feed_valid <= 1'b0;
              r_feed_cnt   <= 2'd0;
              r_drain_cnt  <= '0;
              r_state      <= S_DRAIN;
            end
          endcase
        end

        S_DRAIN: begin
          if (r_drain_cnt == DRN_W'(MMU_LATENCY - 1)) begin
            r_result  <= mmu_c;
            r_out_idx <= '0;
            r_state   <= S_OUT;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
          end
        end

        S_OUT: begin
          if (w_out_fire) begin
            if (r_out_idx == OIDX_W'(NBYTES - 1)) begin
              r_out_idx <= '0;
              r_state   <= S_LOAD;
            end else begin
              r_out_idx <= r_out_idx + OIDX_W'(1);
            end
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_sched.sv
// Scoreboard bench for mmu_sched: expected feeds and result bytes are queued per job
// from a W x A model and popped as the DUT emits them.
module tb_mmu_sched;

  localparam int LAT   = 3;
  localparam int ACC_W = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       mmu_weights;
  logic              mmu_load_w;
  logic              mmu_clear;
  logic [7:0]        mmu_row0;
  logic [7:0]        mmu_row1;
  logic              mmu_feed_valid;
  logic [4*ACC_W-1:0] mmu_c;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  mmu_sched #(.MMU_LATENCY(LAT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mmu_weights(mmu_weights), .mmu_load_w(mmu_load_w), .mmu_clear(mmu_clear),
    .mmu_row0(mmu_row0), .mmu_row1(mmu_row1), .mmu_feed_valid(mmu_feed_valid),
    .mmu_c(mmu_c),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] exp_feed [$];
  logic [63:0] exp_c = '0;
  logic [31:0] prev_w = '0;
  int          since_feed = 1000;
  int          rdy_mode = 0;
  int          n_load_w = 0;
  int          lw_start = 0;
  logic        prev_clear = 1'b0;
  logic        prev_ov = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then let the next rising edge happen.
  task automatic tick();
    logic [2:0] strobes;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    #1;
    if (mmu_feed_valid) since_feed = 0;
    else if (since_feed < 1000) since_feed++;
    strobes = {mmu_load_w, mmu_clear, mmu_feed_valid};
    check("strobe_excl", 64'($countones(strobes) <= 1), 1);
    if (!mmu_feed_valid) check("rows_idle", {mmu_row0, mmu_row1}, 0);
    else if (exp_feed.size() == 0) check("feed_extra", exp_feed.size(), 1);
    else check("feed", {mmu_row0, mmu_row1}, exp_feed.pop_front());
    if (mmu_load_w) n_load_w++;
    if (prev_clear) check("clear_to_feed", mmu_feed_valid, 1);
    if (out_valid && !prev_ov) check("out_start", since_feed, LAT + 1);
    if (prev_stall && out_valid) check("out_hold", out_data, prev_data);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("out_extra", exp_q.size(), 1);
      else check("out_byte", out_data, exp_q.pop_front());
    end
    prev_clear = mmu_clear;
    prev_ov    = out_valid;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    // Only the true capture cycle carries the real result; anything else is noise.
    mmu_c = (since_feed == LAT) ? exp_c : {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 500) begin
      tick();
      budget++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // wv = {W11,W10,W01,W00}, av = {A11,A10,A01,A00}
  task automatic load_job(input logic [31:0] wv, input logic [31:0] av, input int max_gap);
    logic [7:0]  w [4];
    logic [7:0]  a [4];
    logic [15:0] c [4];
    logic [7:0]  bytes [8];
    for (int i = 0; i < 4; i++) begin
      w[i] = wv[8*i +: 8];
      a[i] = av[8*i +: 8];
    end
    c[0] = 16'(w[0] * a[0] + w[1] * a[2]);
    c[1] = 16'(w[0] * a[1] + w[1] * a[3]);
    c[2] = 16'(w[2] * a[0] + w[3] * a[2]);
    c[3] = 16'(w[2] * a[1] + w[3] * a[3]);
    exp_c = {c[3], c[2], c[1], c[0]};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(c[i][15:8]);
      exp_q.push_back(c[i][7:0]);
    end
    exp_feed.push_back({a[0], 8'd0});
    exp_feed.push_back({a[2], a[1]});
    exp_feed.push_back({8'd0, a[3]});
    for (int i = 0; i < 4; i++) begin
      bytes[i]     = w[i];
      bytes[i + 4] = a[i];
    end
    lw_start = n_load_w;
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i], $urandom_range(0, max_gap));
      if (i < 3) check("w_hold", mmu_weights, prev_w);
      if (i == 3) begin
        check("load_w_pulse", mmu_load_w, 1);
        check("weights", mmu_weights, wv);
      end
      if (i == 7) begin
        check("clear_after_load", mmu_clear, 1);
        check("busy_in_clear", busy, 1);
        check("in_ready_busy", in_ready, 0);
      end
    end
    prev_w = wv;
  endtask

  task automatic wait_job_done(input bit junk);
    int budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      tick();
      budget++;
    end
    in_valid = 1'b0;
    check("job_done", exp_q.size(), 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("load_w_once", n_load_w - lw_start, 1);
  endtask

  task automatic wait_out_valid();
    int budget = 0;
    while (!out_valid && budget < 200) begin
      tick();
      budget++;
    end
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    exp_feed.delete();
    repeat (cycles) begin
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_strobes", {mmu_load_w, mmu_clear, mmu_feed_valid}, 0);
      check("rst_weights", mmu_weights, 0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_out_valid", out_valid, 0);
    prev_w = '0;
  endtask

  function automatic logic [31:0] rnd32();
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mmu_c = '0;
    @(negedge clk);
    apply_reset(2);

    // Reference job, everything back-to-back.
    rdy_mode = 0;
    load_job(32'h04030201, 32'h08070605, 0);
    wait_job_done(0);
    check("w_ref", mmu_weights, 32'h04030201);

    // Same job with random back-pressure, a long stall, and junk offered while busy.
    load_job(32'h04030201, 32'h08070605, 0);
    rdy_mode = 2;
    wait_out_valid();
    repeat (30) tick();
    check("stall_out_valid", out_valid, 1);
    check("stall_busy", busy, 1);
    rdy_mode = 1;
    wait_job_done(1);

    // Random operands with gaps on in_valid.
    load_job(rnd32(), rnd32(), 3);
    wait_job_done(0);

    // Reset on FEED beat t1.
    rdy_mode = 0;
    load_job(rnd32(), 32'h44332211, 0);
    tick();
    tick();
    check("t1_row0", mmu_row0, 8'h33);
    check("t1_row1", mmu_row1, 8'h22);
    apply_reset(1);
    check("abort_feed", mmu_feed_valid, 0);

    // Full job after reset, then a back-to-back job with fresh weights.
    load_job(rnd32(), rnd32(), 1);
    wait_job_done(0);
    load_job(32'hA5C3_7E19, rnd32(), 0);
    wait_job_done(0);

    // Reset in the middle of OUT; leftover bytes would hit the next job's scoreboard.
    load_job(rnd32(), rnd32(), 0);
    rdy_mode = 2;
    wait_out_valid();
    rdy_mode = 1;
    repeat (3) tick();
    apply_reset(1);
    rdy_mode = 1;
    load_job(rnd32(), rnd32(), 2);
    wait_job_done(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
